// File: rtl/irq_controller.sv
// ----------------------------------------------------------------------------
// irq_controller
//
// Prioritising interrupt controller between peripheral interrupt lines and
// the processor's one-hot interrupt/acknowledge pair. Rising edges on the
// peripheral raise lines are latched as pending requests, gated by a
// software-programmable mask, and presented to the processor one at a time.
// The processor acknowledge is routed back to the originating peripheral as
// a single-cycle pulse. A four-register block on the shared 8-bit bus lets
// software program the mask, poll and clear pending requests, read the
// controller status and read a serviced-interrupt counter.
//
// Register map (offsets from BASE_ADDR):
//   +0 MASK     R/W   bit i = 1 enables source i, unused bits read 0
//   +1 PENDING  R/W1C pending requests
//   +2 STATUS   RO    bit7 = busy (not idle), bits[2:0] = active index
//   +3 COUNT    RO    serviced-interrupt counter, wraps 255 -> 0
//
// Ports:
//   CLK            in    system clock
//   RESET          in    asynchronous active-high reset
//   BUS_DATA       inout shared data bus, driven only the cycle after a read
//   BUS_ADDR       in    shared address bus
//   BUS_WE         in    bus write enable (1 = write)
//   SRC_IRQ_RAISE  in    peripheral raise lines, held until acknowledged
//   SRC_IRQ_ACK    out   one-cycle acknowledge pulse back to the peripheral
//   CPU_IRQ_RAISE  out   one-hot request to the processor
//   CPU_IRQ_ACK    in    one-hot acknowledge from the processor
// ----------------------------------------------------------------------------
module irq_controller #(
  parameter int         NUM_IRQ     = 2,
  parameter logic [7:0] BASE_ADDR   = 8'hE0,
  parameter bit         ROUND_ROBIN = 1'b0
) (
  input  logic               CLK,
  input  logic               RESET,
  inout  wire  [7:0]         BUS_DATA,
  input  logic [7:0]         BUS_ADDR,
  input  logic               BUS_WE,
  input  logic [NUM_IRQ-1:0] SRC_IRQ_RAISE,
  output logic [NUM_IRQ-1:0] SRC_IRQ_ACK,
  output logic [NUM_IRQ-1:0] CPU_IRQ_RAISE,
  input  logic [NUM_IRQ-1:0] CPU_IRQ_ACK
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Helper functions
  // --------------------------------------------------------------------------

  // Select the next request to service. Returns {found, index}.
  // Fixed priority scans upward from index 0; rotating priority scans upward
  // from the index after the last one serviced, wrapping around.
  function automatic logic [IDX_W:0] pick_next(
    input logic [NUM_IRQ-1:0] req,
    input logic [IDX_W-1:0]   last,
    input bit                 rr
  );
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pi;
    int               start;
    int               p;
    found = 1'b0;
    idx   = '0;
    start = rr ? ((int'(last) + 1) % NUM_IRQ) : 0;
    for (int j = 0; j < NUM_IRQ; j++) begin
      p  = (start + j) % NUM_IRQ;
      pi = IDX_W'(p);
      if (!found && req[pi]) begin
        found = 1'b1;
        idx   = pi;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_IRQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] hist_q;
  logic [7:0]         count_q, count_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   act_q, act_d;
  logic [NUM_IRQ-1:0] src_ack_q, src_ack_d;
  logic               rd_drive_q;
  logic [7:0]         rd_data_q, rd_data_d;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  // A 9-bit difference makes addresses below BASE_ADDR wrap to large values,
  // so one compare covers both ends of the window.
  logic [8:0]         addr_diff;
  logic               addr_hit;
  logic [1:0]         reg_sel;
  logic               wr_mask;
  logic               wr_pend;
  logic               rd_en;
  logic [NUM_IRQ-1:0] wdata;
  logic               unused_bus_bits;

  assign addr_diff       = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
  assign addr_hit        = (addr_diff < 9'd4);
  assign reg_sel         = addr_diff[1:0];
  assign wr_mask         = BUS_WE && addr_hit && (reg_sel == 2'd0);
  assign wr_pend         = BUS_WE && addr_hit && (reg_sel == 2'd1);
  assign rd_en           = !BUS_WE && addr_hit;
  assign wdata           = BUS_DATA[NUM_IRQ-1:0];
  assign unused_bus_bits = ^BUS_DATA;

  // --------------------------------------------------------------------------
  // Request selection and acknowledge qualification
  // --------------------------------------------------------------------------
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               ack_hit;
  logic               busy;
  logic [NUM_IRQ-1:0] act_onehot;

  always_comb begin
    {sel_found, sel_idx} = pick_next(pend_q & mask_q, last_q, ROUND_ROBIN);
  end

  assign act_onehot = onehot(act_q);

  // Only the acknowledge bit matching the active request counts; stray bits
  // and any acknowledge outside ASSERT are ignored.
  assign ack_hit = (state_q == S_ASSERT) && CPU_IRQ_ACK[act_q];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  // ASSERT has no exit other than the matching acknowledge, so masking or
  // clearing the active source never withdraws a request already presented.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (ack_hit) state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  // The request is decoded straight from registered state so an
  // asynchronous reset removes it at once.
  always_comb begin
    CPU_IRQ_RAISE = '0;
    busy          = (state_q != S_IDLE);
    if (state_q == S_ASSERT) CPU_IRQ_RAISE = act_onehot;
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] svc_clr;
  logic [2:0]         act3;

  always_comb begin
    rise      = SRC_IRQ_RAISE & ~hist_q;
    w1c       = wr_pend ? wdata : '0;
    svc_clr   = ack_hit ? act_onehot : '0;
    // A new edge wins over both software and service clears in one cycle.
    pend_d    = (pend_q & ~w1c & ~svc_clr) | rise;
    mask_d    = wr_mask ? wdata : mask_q;
    count_d   = ack_hit ? (count_q + 8'd1) : count_q;
    last_d    = ack_hit ? act_q : last_q;
    act_d     = ((state_q == S_IDLE) && sel_found) ? sel_idx : act_q;
    src_ack_d = svc_clr;
  end

  always_comb begin
    act3 = '0;
    if (state_q != S_IDLE) act3[IDX_W-1:0] = act_q;
  end

  always_comb begin
    rd_data_d = '0;
    case (reg_sel)
      2'd0:    rd_data_d[NUM_IRQ-1:0] = mask_q;
      2'd1:    rd_data_d[NUM_IRQ-1:0] = pend_q;
      2'd2:    rd_data_d = {busy, 4'b0000, act3};
      default: rd_data_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mask_q     <= '1;
      pend_q     <= '0;
      hist_q     <= '0;
      count_q    <= '0;
      last_q     <= IDX_W'(NUM_IRQ - 1);
      act_q      <= '0;
      src_ack_q  <= '0;
      rd_drive_q <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      hist_q     <= SRC_IRQ_RAISE;
      count_q    <= count_d;
      last_q     <= last_d;
      act_q      <= act_d;
      src_ack_q  <= src_ack_d;
      rd_drive_q <= rd_en;
    end
  end

  // --------------------------------------------------------------------------
  // Read data capture (one-cycle read latency)
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (rd_en) rd_data_q <= rd_data_d;
  end

  assign SRC_IRQ_ACK = src_ack_q;
  assign BUS_DATA    = rd_drive_q ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_irq_controller.sv
// ----------------------------------------------------------------------------
// tb_irq_controller
//
// Two controllers share address/write-enable: instance 0 is fixed priority at
// base 8'hE0, instance 1 is round robin at base 8'hE4. Each has its own data
// bus net, peripheral lines and processor acknowledge. A transaction-level
// model (pending/mask/count/last plus the index currently offered) predicts
// register contents and which request the processor should see.
// ----------------------------------------------------------------------------
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic       we;
  logic [7:0] drv;
  logic       oe_a, oe_b;
  logic [1:0] src     [2];
  logic [1:0] cpu_ack [2];
  wire  [1:0] src_ack_w   [2];
  wire  [1:0] cpu_raise_w [2];
  wire  [7:0] bus_a, bus_b;

  assign bus_a = oe_a ? drv : 8'hzz;
  assign bus_b = oe_b ? drv : 8'hzz;

  int vectors = 0;
  int errors  = 0;

  // Reference model state per instance
  logic [1:0] m_pend [2];
  logic [1:0] m_mask [2];
  int         m_cnt  [2];
  int         m_last [2];
  int         m_out  [2];

  always #5 clk = ~clk;

  irq_controller #(.NUM_IRQ(2), .BASE_ADDR(8'hE0), .ROUND_ROBIN(1'b0)) dut_fixed (
    .CLK(clk), .RESET(rst), .BUS_DATA(bus_a), .BUS_ADDR(addr), .BUS_WE(we),
    .SRC_IRQ_RAISE(src[0]), .SRC_IRQ_ACK(src_ack_w[0]),
    .CPU_IRQ_RAISE(cpu_raise_w[0]), .CPU_IRQ_ACK(cpu_ack[0]));

  irq_controller #(.NUM_IRQ(2), .BASE_ADDR(8'hE4), .ROUND_ROBIN(1'b1)) dut_rr (
    .CLK(clk), .RESET(rst), .BUS_DATA(bus_b), .BUS_ADDR(addr), .BUS_WE(we),
    .SRC_IRQ_RAISE(src[1]), .SRC_IRQ_ACK(src_ack_w[1]),
    .CPU_IRQ_RAISE(cpu_raise_w[1]), .CPU_IRQ_ACK(cpu_ack[1]));

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] base(input int u);
    return (u == 0) ? 8'hE0 : 8'hE4;
  endfunction

  function automatic logic [1:0] oh2(input int k);
    return (k == 0) ? 2'b01 : 2'b10;
  endfunction

  // Spec rule: fixed = lowest enabled pending index; round robin = first
  // enabled pending index after the last serviced one, wrapping.
  function automatic int pick_model(input int u);
    logic [1:0] req;
    int         i;
    req = m_pend[u] & m_mask[u];
    for (int j = 1; j <= 2; j++) begin
      i = (u == 0) ? (j - 1) : ((m_last[u] + j) % 2);
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_reg(input int u, input int off);
    case (off)
      0:       return {6'b0, m_mask[u]};
      1:       return {6'b0, m_pend[u]};
      2:       return (m_out[u] >= 0) ? (8'h80 | 8'(m_out[u])) : 8'h00;
      default: return 8'(m_cnt[u]);
    endcase
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_pend[u] = 2'b00;
      m_mask[u] = 2'b11;
      m_cnt[u]  = 0;
      m_last[u] = 1;
      m_out[u]  = -1;
    end
  endtask

  task automatic settle();
    repeat (3) tick();
    for (int u = 0; u < 2; u++)
      if (m_out[u] < 0) m_out[u] = pick_model(u);
  endtask

  task automatic bus_read(input int u, input int off, output logic [7:0] d);
    addr = base(u) + 8'(off);
    we   = 1'b0;
    tick();
    d    = (u == 0) ? bus_a : bus_b;
    addr = 8'h00;
    tick();
  endtask

  task automatic read_expect(input int u, input int off, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    bus_read(u, off, d);
    chk(tag, d, exp);
  endtask

  task automatic bus_write(input int u, input int off, input logic [7:0] val);
    addr = base(u) + 8'(off);
    we   = 1'b1;
    drv  = val;
    oe_a = 1'b1;
    oe_b = 1'b1;
    tick();
    we   = 1'b0;
    oe_a = 1'b0;
    oe_b = 1'b0;
    addr = 8'h00;
  endtask

  task automatic write_mask(input int u, input logic [7:0] val);
    bus_write(u, 0, val);
    m_mask[u] = val[1:0];
    settle();
  endtask

  task automatic write_w1c(input int u, input logic [7:0] val);
    bus_write(u, 1, val);
    m_pend[u] = m_pend[u] & ~val[1:0];
    settle();
  endtask

  // The bench drives 0 onto the bus net; any DUT drive shows as contention.
  task automatic hiz_check(input int u, input logic [7:0] a, input string tag);
    logic [7:0] d;
    addr = a;
    we   = 1'b0;
    tick();
    drv = 8'h00;
    if (u == 0) oe_a = 1'b1; else oe_b = 1'b1;
    #1;
    d = (u == 0) ? bus_a : bus_b;
    chk(tag, d, 8'h00);
    oe_a = 1'b0;
    oe_b = 1'b0;
    addr = 8'h00;
    tick();
  endtask

  task automatic raise(input int u, input logic [1:0] bits);
    m_pend[u] = m_pend[u] | (bits & ~src[u]);
    src[u]    = src[u] | bits;
    settle();
  endtask

  task automatic lower(input int u, input logic [1:0] bits);
    src[u] = src[u] & ~bits;
    tick();
  endtask

  task automatic check_raise(input int u, input string tag);
    logic [1:0] e;
    e = (m_out[u] >= 0) ? oh2(m_out[u]) : 2'b00;
    chk(tag, {6'b0, cpu_raise_w[u]}, {6'b0, e});
  endtask

  task automatic service(input int u);
    int         k;
    logic [1:0] oh;
    k = m_out[u];
    if (k >= 0) begin
      oh = oh2(k);
      for (int i = 0; i < 8 && cpu_raise_w[u] == 2'b00; i++) tick();
      chk("svc_raise", {6'b0, cpu_raise_w[u]}, {6'b0, oh});
      cpu_ack[u] = ~oh;
      tick();
      chk("svc_other_ack_raise", {6'b0, cpu_raise_w[u]}, {6'b0, oh});
      chk("svc_other_ack_src", {6'b0, src_ack_w[u]}, 8'h00);
      cpu_ack[u] = oh;
      tick();
      cpu_ack[u] = 2'b00;
      chk("svc_src_ack", {6'b0, src_ack_w[u]}, {6'b0, oh});
      chk("svc_holdoff_raise", {6'b0, cpu_raise_w[u]}, 8'h00);
      src[u] = src[u] & ~oh;
      tick();
      chk("svc_src_ack_one_cycle", {6'b0, src_ack_w[u]}, 8'h00);
      chk("svc_gap_raise", {6'b0, cpu_raise_w[u]}, 8'h00);
      m_pend[u] = m_pend[u] & ~oh;
      m_cnt[u]  = (m_cnt[u] + 1) % 256;
      m_last[u] = k;
      m_out[u]  = -1;
      settle();
    end
  endtask

  initial begin
    int         u;
    int         act;
    logic [1:0] bits;
    logic [7:0] val;
    logic [7:0] d;

    rst = 1'b1; addr = 8'h00; we = 1'b0; drv = 8'h00; oe_a = 1'b0; oe_b = 1'b0;
    src[0] = 2'b00; src[1] = 2'b00; cpu_ack[0] = 2'b00; cpu_ack[1] = 2'b00;
    model_reset();
    #1;
    chk("rst_cpu_raise0", {6'b0, cpu_raise_w[0]}, 8'h00);
    chk("rst_src_ack0",   {6'b0, src_ack_w[0]},   8'h00);
    chk("rst_cpu_raise1", {6'b0, cpu_raise_w[1]}, 8'h00);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Register reset values and high-Z outside the window
    read_expect(0, 0, 8'h03, "rst_mask");
    read_expect(0, 1, 8'h00, "rst_pending");
    read_expect(0, 2, 8'h00, "rst_status");
    read_expect(0, 3, 8'h00, "rst_count");
    read_expect(1, 0, 8'h03, "rst_mask_rr");
    hiz_check(0, 8'hE8, "hiz_above");
    hiz_check(0, 8'hDF, "hiz_below");
    read_expect(0, 0, 8'h03, "mask_reread");
    hiz_check(0, 8'hE4, "hiz_other_block");

    // Single request on source 1
    raise(0, 2'b10);
    chk("single_raise", {6'b0, cpu_raise_w[0]}, 8'h02);
    read_expect(0, 1, 8'h02, "single_pending");
    read_expect(0, 2, 8'h81, "single_status");
    service(0);
    read_expect(0, 1, 8'h00, "single_pending_clr");
    read_expect(0, 3, 8'h01, "single_count");

    // Simultaneous requests, fixed priority: 0 then 1
    raise(0, 2'b11);
    chk("fixed_first", {6'b0, cpu_raise_w[0]}, 8'h01);
    service(0);
    chk("fixed_second", {6'b0, cpu_raise_w[0]}, 8'h02);
    service(0);

    // Round robin: service 0 so last = 0, then both -> 1 first
    raise(1, 2'b01);
    service(1);
    raise(1, 2'b11);
    chk("rr_first", {6'b0, cpu_raise_w[1]}, 8'h02);
    service(1);
    chk("rr_second", {6'b0, cpu_raise_w[1]}, 8'h01);
    service(1);

    // Masked source stays pending until unmasked
    write_mask(0, 8'h01);
    raise(0, 2'b10);
    read_expect(0, 1, 8'h02, "masked_pending");
    chk("masked_no_raise", {6'b0, cpu_raise_w[0]}, 8'h00);
    write_mask(0, 8'h03);
    chk("unmask_raise", {6'b0, cpu_raise_w[0]}, 8'h02);
    service(0);

    // W1C while masked drops the request entirely
    write_mask(0, 8'h01);
    raise(0, 2'b10);
    write_w1c(0, 8'h02);
    read_expect(0, 1, 8'h00, "w1c_pending");
    write_mask(0, 8'h03);
    chk("w1c_no_raise", {6'b0, cpu_raise_w[0]}, 8'h00);
    lower(0, 2'b10);

    // Masking and clearing during ASSERT do not retract the request
    raise(0, 2'b01);
    write_mask(0, 8'h00);
    chk("assert_masked_keep", {6'b0, cpu_raise_w[0]}, 8'h01);
    write_w1c(0, 8'h01);
    chk("assert_w1c_keep", {6'b0, cpu_raise_w[0]}, 8'h01);
    read_expect(0, 2, 8'h80, "assert_status");
    service(0);
    write_mask(0, 8'h03);

    // Acknowledge while idle is ignored
    cpu_ack[0] = 2'b11;
    repeat (3) tick();
    chk("idle_ack_src", {6'b0, src_ack_w[0]}, 8'h00);
    chk("idle_ack_raise", {6'b0, cpu_raise_w[0]}, 8'h00);
    cpu_ack[0] = 2'b00;
    read_expect(0, 3, 8'(m_cnt[0]), "idle_ack_count");

    // A rising edge wins over a W1C of the same bit on the same edge
    src[0] = src[0] | 2'b01;
    bus_write(0, 1, 8'h01);
    m_pend[0] = m_pend[0] | 2'b01;
    settle();
    chk("set_over_w1c", {6'b0, cpu_raise_w[0]}, 8'h01);
    service(0);

    // Reset during ASSERT
    raise(0, 2'b10);
    chk("pre_reset_raise", {6'b0, cpu_raise_w[0]}, 8'h02);
    rst = 1'b1;
    #1;
    chk("reset_async_raise", {6'b0, cpu_raise_w[0]}, 8'h00);
    chk("reset_async_src_ack", {6'b0, src_ack_w[0]}, 8'h00);
    src[0] = 2'b00; src[1] = 2'b00;
    tick();
    chk("reset_hold_src_ack", {6'b0, src_ack_w[0]}, 8'h00);
    rst = 1'b0;
    model_reset();
    tick();
    read_expect(0, 3, 8'h00, "reset_count");
    read_expect(0, 1, 8'h00, "reset_pending");

    // Counter wrap
    for (int n = 0; n < 255; n++) begin
      raise(0, 2'b01);
      service(0);
    end
    read_expect(0, 3, 8'hFF, "count_255");
    raise(0, 2'b01);
    service(0);
    read_expect(0, 3, 8'h00, "count_wrap");

    // Randomised traffic against the model
    for (int n = 0; n < 300; n++) begin
      u    = int'($urandom_range(1));
      act  = int'($urandom_range(5));
      bits = 2'($urandom_range(3));
      val  = 8'($urandom_range(255));
      case (act)
        0: raise(u, bits);
        1: write_mask(u, val);
        2: write_w1c(u, val);
        3: begin
          int off;
          off = int'($urandom_range(3));
          bus_read(u, off, d);
          chk("rnd_read", d, model_reg(u, off));
        end
        4: if (m_out[u] >= 0) service(u); else lower(u, bits);
        default: lower(u, bits);
      endcase
      check_raise(u, "rnd_raise");
      chk("rnd_src_ack", {6'b0, src_ack_w[u]}, 8'h00);
    end
    for (int k = 0; k < 2; k++) begin
      read_expect(k, 1, model_reg(k, 1), "final_pending");
      read_expect(k, 3, model_reg(k, 3), "final_count");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritising interrupt controller between the peripheral interrupt lines (timer, mouse) and the processor's interrupt/acknowledge pair.
- Latches requests, applies a bus-programmable mask, and presents exactly one request at a time to the processor.
- Routes the processor acknowledge back to the originating peripheral.
- Bus-mapped register block on the shared 8-bit data/address bus, so software can mask sources, poll pending requests and clear them.

Parameters:
- NUM_IRQ, 2, number of sources and processor interrupt lines (1..8)
- BASE_ADDR, 8'hE0, bus address of register 0; block decodes BASE_ADDR..BASE_ADDR+3
- ROUND_ROBIN, 0, 0 = fixed priority (index 0 highest); 1 = rotating priority starting after last serviced index

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- BUS_DATA  inout  8  shared data bus; driven only during register reads, else high-Z
- BUS_ADDR  in  8  shared address bus
- BUS_WE  in  1  bus write enable (1 = write)
- SRC_IRQ_RAISE  in  NUM_IRQ  peripheral raise lines; held high until acknowledged
- SRC_IRQ_ACK  out  NUM_IRQ  one-cycle acknowledge pulse to peripheral
- CPU_IRQ_RAISE  out  NUM_IRQ  one-hot request to processor
- CPU_IRQ_ACK  in  NUM_IRQ  processor acknowledge, one-hot

Behaviour:
- Reset (async, immediate):
  - all outputs 0, BUS_DATA high-Z
  - mask = all ones (enabled), pending = 0, serviced count = 0
  - FSM = IDLE, last-serviced index = NUM_IRQ-1, edge-detect history = 0
- Registers:
  - BASE+0 MASK: R/W; bit i = 1 enables source i; bits >= NUM_IRQ read 0
  - BASE+1 PENDING: read returns pending; write is write-1-to-clear
  - BASE+2 STATUS: read-only; bit7 = FSM not IDLE, bits[2:0] = active index (0 when IDLE)
  - BASE+3 COUNT: read-only; 8-bit serviced-interrupt counter, wraps 255 -> 0
- Bus writes: take effect on the clock edge where BUS_WE = 1 and the address matches.
- Bus reads:
  - when BUS_WE = 0 and the address is in range, the register value is captured on a clock edge and driven onto BUS_DATA for the following cycle
  - drive enable is registered from the same decode; high-Z otherwise
  - one-cycle read latency, matching the RAM and peripherals
- Request capture:
  - pending[i] sets on a rising edge of SRC_IRQ_RAISE[i] (registered history, 1-cycle detect latency)
  - set has priority over W1C clear and over service clear in the same cycle
- FSM states and transitions:
  - IDLE: if (pending & mask) != 0, select index k and go to ASSERT next edge
    - fixed mode: k = lowest set bit
    - round robin: k = first set bit scanning upward from last+1, wrapping
  - ASSERT:
    - CPU_IRQ_RAISE = one-hot k (registered); other CPU_IRQ_ACK bits ignored
    - on CPU_IRQ_ACK[k] = 1: clear pending[k], SRC_IRQ_ACK[k] = 1 for exactly one cycle, CPU_IRQ_RAISE -> 0, COUNT += 1, last = k, go to HOLDOFF
  - HOLDOFF: one cycle, all raises low (processor sees a deassert between requests), then IDLE
- Boundary conditions:
  - Masking source k, or W1C-clearing pending[k], during ASSERT does not retract the request; completes on ack.
  - No acknowledge timeout: ASSERT waits indefinitely.
  - Minimum spacing between two serviced requests: 3 cycles (ASSERT, HOLDOFF, IDLE).
  - A source re-raising while its previous request is still pending is absorbed; no counting.
  - CPU_IRQ_ACK is ignored in IDLE/HOLDOFF; SRC_IRQ_ACK never pulses there.
  - Reset during ASSERT drops CPU_IRQ_RAISE immediately; no SRC_IRQ_ACK is issued.

Test Plan:
- Reset, then read BASE+0..3 -> 8'h03, 8'h00, 8'h00, 8'h00 (NUM_IRQ = 2); BUS_DATA high-Z for out-of-range addresses.
- Raise SRC[1] -> PENDING = 8'h02; CPU_IRQ_RAISE = 2'b10 within 3 cycles; ack[1] -> SRC_IRQ_ACK = 2'b10 for one cycle, PENDING = 0, COUNT = 1.
- Raise SRC[0] and SRC[1] on the same edge, fixed mode -> index 0 serviced first, then index 1 after HOLDOFF.
- Same stimulus with ROUND_ROBIN = 1 and last = 0 -> index 1 serviced first.
- Write MASK = 8'h01, raise SRC[1] -> PENDING = 8'h02, no CPU raise. Write MASK = 8'h03 -> CPU_IRQ_RAISE = 2'b10. Repeat with a W1C of 8'h02 while masked -> no service.
- Assert RESET while in ASSERT -> all outputs 0 in the same cycle, no SRC_IRQ_ACK. Drive 256 service cycles -> COUNT wraps to 0.
